// File: rtl/fifo_sync_param_if.sv
// Request/status bundle between a channel datapath and its FIFO.
interface fifo_sync_param_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
);
  logic              ena;
  logic              wr_en;
  logic [WIDTH-1:0]  wr_data;
  logic              rd_en;
  logic              clr_err;
  logic [WIDTH-1:0]  rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   level;
  logic              overflow;
  logic              underflow;

  modport master (
    output ena, wr_en, wr_data, rd_en, clr_err,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );

  modport slave (
    input  ena, wr_en, wr_data, rd_en, clr_err,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised synchronous FIFO with occupancy level, programmable
// almost-full/almost-empty thresholds, sticky error flags and an optional
// first-word-fall-through read port.
module fifo_sync_param #(
  parameter int WIDTH    = 8,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input logic              clk,
  input logic              rst_n,
  fifo_sync_param_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int LV_W  = ADDR_W + 1;
  localparam logic [ADDR_W:0] DEPTH_LV = LV_W'(DEPTH);
  localparam logic [ADDR_W:0] AF_LV    = LV_W'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_LV    = LV_W'(AE_LEVEL);

  if (!((AE_LEVEL >= 0) && (AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH) && (ADDR_W >= 1) && (WIDTH >= 1)))
  begin : g_bad_params
    $error("fifo_sync_param: illegal parameters (need AE_LEVEL < AF_LEVEL <= DEPTH)");
  end

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              full, empty, wr_acc, rd_acc;

  // Flags come straight from the level register so acceptance uses pre-edge state.
  assign full   = (level_q == DEPTH_LV);
  assign empty  = (level_q == '0);
  assign wr_acc = bus.ena & bus.wr_en & ~full;
  assign rd_acc = bus.ena & bus.rd_en & ~empty;

  // Pointer, occupancy and sticky error next-state; set beats clear.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    if (bus.ena) begin
      overflow_d  = (bus.wr_en & full)  | (overflow_q  & ~bus.clr_err);
      underflow_d = (bus.rd_en & empty) | (underflow_q & ~bus.clr_err);
    end
  end

  // Control state register; reset empties the FIFO without touching storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is shown directly; rd_en only pops it.
    assign bus.rd_data  = mem_q[rd_ptr_q];
    assign bus.rd_valid = ~empty;
  end else begin : g_reg
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;

    // Registered read: data and a one-cycle valid pulse land at the pop edge.
    always_comb begin
      rd_data_d  = rd_data_q;
      rd_valid_d = rd_valid_q;
      if (bus.ena) rd_valid_d = rd_acc;
      if (rd_acc)  rd_data_d  = mem_q[rd_ptr_q];
    end

    // Read output register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_data_q  <= rd_data_d;
        rd_valid_q <= rd_valid_d;
      end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
  end

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (level_q >= AF_LV);
  assign bus.almost_empty = (level_q <= AE_LV);
  assign bus.level        = level_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: a registered-read and an FWFT instance run the
// same stimulus and are compared against a queue-based reference model.
module tb_fifo_sync_param;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena_r = 1'b0, wr_en_r = 1'b0, rd_en_r = 1'b0, clr_r = 1'b0;
  logic [7:0] wr_data_r = 8'h00;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mq[$];
  logic       m_ovf = 1'b0, m_unf = 1'b0, m_rdv = 1'b0;
  logic [7:0] m_rdd = 8'h00;

  always #5 clk = ~clk;

  fifo_sync_param_if #(.WIDTH(8), .ADDR_W(4)) if0 ();
  fifo_sync_param_if #(.WIDTH(8), .ADDR_W(4)) if1 ();

  assign if0.ena = ena_r;   assign if1.ena = ena_r;
  assign if0.wr_en = wr_en_r; assign if1.wr_en = wr_en_r;
  assign if0.wr_data = wr_data_r; assign if1.wr_data = wr_data_r;
  assign if0.rd_en = rd_en_r; assign if1.rd_en = rd_en_r;
  assign if0.clr_err = clr_r; assign if1.clr_err = clr_r;

  fifo_sync_param #(.WIDTH(8), .ADDR_W(4), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  fifo_sync_param #(.WIDTH(8), .ADDR_W(4), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0; m_unf = 1'b0; m_rdv = 1'b0; m_rdd = 8'h00;
  endtask

  // One clock of FIFO behaviour from occupancy rules, using pre-edge occupancy.
  task automatic model_step();
    int  n = mq.size();
    bit  is_full = (n == 16);
    bit  is_empty = (n == 0);
    if (ena_r) begin
      if (rd_en_r && !is_empty) begin
        m_rdd = mq.pop_front();
        m_rdv = 1'b1;
      end else begin
        m_rdv = 1'b0;
      end
      if (wr_en_r && !is_full) mq.push_back(wr_data_r);
      m_ovf = (wr_en_r && is_full)  || (m_ovf && !clr_r);
      m_unf = (rd_en_r && is_empty) || (m_unf && !clr_r);
    end
  endtask

  task automatic check_all(input string ph);
    int n = mq.size();
    chk({ph, ".level"},    32'(if0.level),        32'(n));
    chk({ph, ".full"},     32'(if0.full),         32'(n == 16));
    chk({ph, ".empty"},    32'(if0.empty),        32'(n == 0));
    chk({ph, ".afull"},    32'(if0.almost_full),  32'(n >= 14));
    chk({ph, ".aempty"},   32'(if0.almost_empty), 32'(n <= 2));
    chk({ph, ".ovf"},      32'(if0.overflow),     32'(m_ovf));
    chk({ph, ".unf"},      32'(if0.underflow),    32'(m_unf));
    chk({ph, ".rdv"},      32'(if0.rd_valid),     32'(m_rdv));
    chk({ph, ".rdd"},      32'(if0.rd_data),      32'(m_rdd));
    chk({ph, ".f_level"},  32'(if1.level),        32'(n));
    chk({ph, ".f_ovf"},    32'(if1.overflow),     32'(m_ovf));
    chk({ph, ".f_unf"},    32'(if1.underflow),    32'(m_unf));
    chk({ph, ".f_rdv"},    32'(if1.rd_valid),     32'(n != 0));
    if (n != 0) chk({ph, ".f_rdd"}, 32'(if1.rd_data), 32'(mq[0]));
  endtask

  task automatic step(input string ph, input logic w, input logic r, input logic [7:0] d,
                      input logic e = 1'b1, input logic c = 1'b0);
    ena_r = e; wr_en_r = w; rd_en_r = r; wr_data_r = d; clr_r = c;
    model_step();
    @(posedge clk);
    #1;
    check_all(ph);
  endtask

  initial begin
    // Reset state
    model_reset();
    #3 check_all("reset");
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill to full, then an overflowing write
    for (int i = 0; i < 16; i++) step("fill", 1'b1, 1'b0, 8'(i));
    step("fill_ovf", 1'b1, 1'b0, 8'hAA);

    // Drain in order, then an underflowing read
    for (int i = 0; i < 16; i++) step("drain", 1'b0, 1'b1, 8'h00);
    step("drain_unf", 1'b0, 1'b1, 8'h00);
    step("clr0", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // Pointer wrap
    for (int i = 0; i < 10; i++) step("wrap_w1", 1'b1, 1'b0, 8'(8'h10 + i));
    for (int i = 0; i < 10; i++) step("wrap_r1", 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 12; i++) step("wrap_w2", 1'b1, 1'b0, 8'(8'h20 + i));
    for (int i = 0; i < 12; i++) step("wrap_r2", 1'b0, 1'b1, 8'h00);

    // Simultaneous requests at full, mid, and empty
    for (int i = 0; i < 16; i++) step("sim_fill", 1'b1, 1'b0, 8'(8'h40 + i));
    step("sim_full", 1'b1, 1'b1, 8'hEE);
    for (int i = 0; i < 10; i++) step("sim_dn", 1'b0, 1'b1, 8'h00);
    step("sim_mid", 1'b1, 1'b1, 8'h77);
    for (int i = 0; i < 5; i++) step("sim_dn2", 1'b0, 1'b1, 8'h00);
    step("sim_empty", 1'b1, 1'b1, 8'h99);
    step("sim_clr", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    step("sim_pop", 1'b0, 1'b1, 8'h00);

    // First-word-fall-through sequence
    step("fw_w5a", 1'b1, 1'b0, 8'h5A);
    step("fw_idle", 1'b0, 1'b0, 8'h00);
    step("fw_w5b", 1'b1, 1'b0, 8'h5B);
    step("fw_pop1", 1'b0, 1'b1, 8'h00);
    step("fw_pop2", 1'b0, 1'b1, 8'h00);

    // Enable low ignores everything
    for (int i = 0; i < 4; i++) step("ena_lo", 1'b1, 1'b1, 8'hC3, 1'b0, 1'b1);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) step("prerst", 1'b1, 1'b0, 8'(8'h60 + i));
    step("prerst_unf", 1'b0, 1'b1, 8'h00);
    step("prerst_unf2", 1'b0, 1'b0, 8'h00);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("async_rst");
    #1 rst_n = 1'b1;
    step("post_w", 1'b1, 1'b0, 8'h77);
    step("post_r", 1'b0, 1'b1, 8'h00);

    // Randomised traffic with fill-biased then drain-biased phases
    for (int i = 0; i < 600; i++) begin
      int wb = ((i / 100) % 2 == 0) ? 70 : 35;
      int rb = ((i / 100) % 2 == 0) ? 35 : 70;
      step("rand",
           logic'($urandom_range(0, 99) < wb),
           logic'($urandom_range(0, 99) < rb),
           8'($urandom),
           logic'($urandom_range(0, 99) < 90),
           logic'($urandom_range(0, 99) < 5));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
